alu_seq: RTL and testbench

- Multi-cycle arithmetic unit sitting directly downstream of the CPU control unit.
- Accepts one-cycle `alu_req` pulses carrying an operation code and two REG_SIZE operands.
- Computes ADD/SUB in one cycle; MUL by iterative shift-add and DIV by restoring division, each taking REG_SIZE cycles.
- Returns the result with a one-cycle `alu_done` pulse. The control unit writes the result to RAM in that same cycle.

---
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// One request at a time; the result is reported with a one-cycle alu_done pulse.
module alu_seq #(
    parameter int REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    input  logic                alu_req,
    output logic                alu_busy,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
    output logic                alu_ovf,
    output logic                alu_zero
);
    localparam int N  = REG_SIZE;
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]    opc;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] mcand, acc, acc_nxt;
    logic [N-1:0]  mplier;
    logic [N-1:0]  rem, dvd, dvs;
    logic [N:0]    r_sh, r_sub;
    logic          ge;
    logic [N:0]    sum;
    logic          unused_ok;

    // Multiply step: conditional add of the shifted multiplicand
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    // Divide step: bring in the next dividend bit and try to subtract the divisor
    assign r_sh  = {rem, dvd[N-1]};
    assign ge    = r_sh >= {1'b0, dvs};
    assign r_sub = r_sh - {1'b0, dvs};
    assign unused_ok = r_sub[N];

    assign sum      = {1'b0, alu_op1} + {1'b0, alu_op2};
    assign alu_zero = (alu_res == '0);

    always_comb begin
        state_nxt = state;
        alu_busy  = 1'b0;
        alu_done  = 1'b0;
        case (state)
            IDLE: begin
                if (alu_req) begin
                    if (alu_operation == OP_MUL || (alu_operation == OP_DIV && alu_op2 != '0))
                        state_nxt = CALC;
                    else
                        state_nxt = DONE;
                end
            end
            CALC: begin
                alu_busy = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                alu_busy  = 1'b1;
                alu_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            alu_res <= '0;
            alu_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (alu_req) begin
                    opc    <= alu_operation;
                    cnt    <= CW'(N - 1);
                    mcand  <= {{N{1'b0}}, alu_op1};
                    mplier <= alu_op2;
                    acc    <= '0;
                    rem    <= '0;
                    dvd    <= alu_op1;
                    dvs    <= alu_op2;
                    case (alu_operation)
                        OP_ADD: begin
                            alu_res <= sum[N-1:0];
                            alu_ovf <= sum[N];
                        end
                        OP_SUB: begin
                            alu_res <= alu_op1 - alu_op2;
                            alu_ovf <= alu_op1 < alu_op2;
                        end
                        OP_DIV: if (alu_op2 == '0) begin
                            alu_res <= '1;
                            alu_ovf <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (opc == OP_MUL) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        if (cnt == '0) begin
                            alu_res <= acc_nxt[N-1:0];
                            alu_ovf <= |acc_nxt[2*N-1:N];
                        end
                    end else begin
                        rem <= ge ? r_sub[N-1:0] : r_sh[N-1:0];
                        dvd <= {dvd[N-2:0], ge};
                        if (cnt == '0) begin
                            alu_res <= {dvd[N-2:0], ge};
                            alu_ovf <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed plus random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int N    = 8;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   alu_operation;
    logic [N-1:0] alu_op1, alu_op2;
    logic         alu_req;
    logic         alu_busy, alu_done, alu_ovf, alu_zero;
    logic [N-1:0] alu_res;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.REG_SIZE(N)) dut (
        .clk(clk), .rst(rst), .alu_operation(alu_operation),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_req(alu_req),
        .alu_busy(alu_busy), .alu_done(alu_done), .alu_res(alu_res),
        .alu_ovf(alu_ovf), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int ovf, output int lat);
        int p;
        case (op)
            0: begin res = (a + b) & MASK; ovf = (a + b > MASK) ? 1 : 0; lat = 1; end
            1: begin res = (a - b) & MASK; ovf = (a < b) ? 1 : 0; lat = 1; end
            2: begin p = a * b; res = p & MASK; ovf = ((p >> N) != 0) ? 1 : 0; lat = N + 1; end
            default: begin
                if (b == 0) begin res = MASK; ovf = 1; lat = 1; end
                else begin res = a / b; ovf = 0; lat = N + 1; end
            end
        endcase
    endfunction

    // Issue one request, then scramble operands (and optionally fire stray
    // requests) until alu_done, checking latency, result and the single pulse.
    task automatic run_op(input int op, input int a, input int b, input bit noise);
        int res, ovf, lat, cyc;
        model(op, a, b, res, ovf, lat);
        @(negedge clk);
        alu_req = 1'b1; alu_operation = op[1:0]; alu_op1 = a[N-1:0]; alu_op2 = b[N-1:0];
        @(negedge clk);
        alu_req = 1'b0;
        cyc = 1;
        while (!alu_done && cyc <= N + 4) begin
            chk("busy_calc", alu_busy, 1);
            alu_op1 = N'($urandom); alu_op2 = N'($urandom);
            if (noise) begin alu_req = 1'b1; alu_operation = 2'($urandom); end
            @(negedge clk);
            alu_req = 1'b0;
            cyc++;
        end
        chk($sformatf("latency op%0d %0d,%0d", op, a, b), cyc, lat);
        chk($sformatf("res op%0d %0d,%0d", op, a, b), alu_res, res);
        chk($sformatf("ovf op%0d %0d,%0d", op, a, b), alu_ovf, ovf);
        chk("zero", alu_zero, (res == 0) ? 1 : 0);
        chk("busy_done", alu_busy, 1);
        if (noise) begin
            alu_req = 1'b1; alu_operation = 2'($urandom);
            alu_op1 = N'($urandom); alu_op2 = N'($urandom);
        end
        @(negedge clk);
        alu_req = 1'b0;
        chk("done_single", alu_done, 0);
        chk("busy_idle", alu_busy, 0);
        chk("res_hold", alu_res, res);
    endtask

    initial begin
        rst = 1'b1; alu_req = 1'b0; alu_operation = '0; alu_op1 = '0; alu_op2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", alu_done, 0);
        chk("rst_busy", alu_busy, 0);
        chk("rst_res", alu_res, 0);
        chk("rst_ovf", alu_ovf, 0);
        chk("rst_zero", alu_zero, 1);
        rst = 1'b0;

        run_op(0, 200, 100, 0);
        run_op(1, 5, 7, 0);
        run_op(1, 7, 7, 0);
        run_op(2, 13, 11, 0);
        run_op(2, 16, 16, 0);
        run_op(2, 255, 0, 0);
        run_op(3, 100, 7, 0);
        run_op(3, 7, 100, 0);
        run_op(3, 255, 1, 0);
        run_op(3, 42, 0, 0);
        run_op(2, 13, 11, 1);
        run_op(0, 9, 250, 1);
        run_op(3, 200, 3, 1);

        // Reset in the middle of a multiply abandons it silently
        @(negedge clk);
        alu_req = 1'b1; alu_operation = 2'b10; alu_op1 = 8'd13; alu_op2 = 8'd11;
        @(negedge clk);
        alu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", alu_busy, 0);
        chk("rst_mid_done", alu_done, 0);
        chk("rst_mid_res", alu_res, 0);
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            chk("rst_mid_nodone", alu_done, 0);
        end
        run_op(0, 1, 2, 0);

        for (int i = 0; i < 100; i++) begin
            int op, a, b;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, MASK));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MASK));
            run_op(op, a, b, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
